// File: rtl/pool_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pool_out_buffer
// Brief    : Captures one pooled feature-map frame into a register array,
//            then replays it in raster order over a valid/ready stream.
//            Reports when the upstream accelerator may start a new frame.
// Revision : 1.0 - initial release
// ============================================================================
module pool_out_buffer #(
    parameter int N     = 16,
    parameter int M     = 4,
    parameter int DEPTH = M * M,
    parameter int CW    = 5
) (
    input  logic         clk,
    input  logic         global_rst,
    input  logic [N-1:0] data_in,
    input  logic         valid_in,
    input  logic         end_in,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         dout_last,
    output logic         frame_rdy,
    output logic         frame_done,
    output logic         short_frame,
    output logic         overflow
);

    // Index width into the storage array; the counters carry one extra bit
    // so that a completely full buffer (count == DEPTH) is representable.
    localparam int          c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] c_ONE   = CW'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rd_idx;
    logic [N-1:0]  r_mem [DEPTH];
    logic          r_frame_done;
    logic          r_short;
    logic          r_ovf;

    logic          w_wr_en;
    logic          w_xfer;
    logic          w_drain_done;
    logic          w_short_set;
    logic          w_ovf_set;
    logic          w_last;
    logic [CW-1:0] w_wr_cnt_after;

    // Last word of the frame is the one just below the captured count.
    assign w_last         = (r_rd_idx == (r_wr_cnt - c_ONE));
    assign w_wr_cnt_after = valid_in ? (r_wr_cnt + c_ONE) : r_wr_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the per-cycle write/transfer/flag strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_en      = 1'b0;
        w_xfer       = 1'b0;
        w_drain_done = 1'b0;
        w_short_set  = 1'b0;
        w_ovf_set    = 1'b0;
        case (r_state)
            c_IDLE: begin
                // A lone end_in here belongs to no frame and is ignored.
                if (valid_in) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = c_CAPTURE;
                end
            end
            c_CAPTURE: begin
                w_wr_en = valid_in && (r_wr_cnt < c_DEPTH);
                if (valid_in && (r_wr_cnt == (c_DEPTH - c_ONE))) begin
                    w_state_nxt = c_DRAIN;
                end else if (end_in) begin
                    // A sample arriving with end_in is written and counted.
                    w_state_nxt = c_DRAIN;
                    w_short_set = (w_wr_cnt_after < c_DEPTH);
                end
            end
            c_DRAIN: begin
                // Buffer is busy replaying: new samples have nowhere to go.
                w_ovf_set = valid_in;
                w_xfer    = dout_ready;
                if (dout_ready && w_last) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_cnt[c_AW-1:0]] <= data_in;
        end
    end

    // Counters, completion pulse and sticky error flags.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            r_wr_cnt     <= '0;
            r_rd_idx     <= '0;
            r_frame_done <= 1'b0;
            r_short      <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_frame_done <= w_drain_done;
            if (w_drain_done) begin
                r_wr_cnt <= '0;
                r_rd_idx <= '0;
            end else begin
                if (w_wr_en) begin
                    r_wr_cnt <= r_wr_cnt + c_ONE;
                end
                if (w_xfer) begin
                    r_rd_idx <= r_rd_idx + c_ONE;
                end
            end
            if (w_short_set) begin
                r_short <= 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Drain outputs come straight from registered state, so they cannot
    // change while the consumer holds off ready.
    assign dout_valid  = (r_state == c_DRAIN);
    assign dout        = dout_valid ? r_mem[r_rd_idx[c_AW-1:0]] : '0;
    assign dout_last   = dout_valid && w_last;
    assign frame_rdy   = (r_state != c_DRAIN);
    assign frame_done  = r_frame_done;
    assign short_frame = r_short;
    assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pool_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_out_buffer
// Brief    : Directed self-checking bench for pool_out_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_out_buffer;

    localparam int N     = 16;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         global_rst;
    logic [N-1:0] data_in;
    logic         valid_in;
    logic         end_in;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;
    logic         frame_rdy;
    logic         frame_done;
    logic         short_frame;
    logic         overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0] exp_q [DEPTH];

    pool_out_buffer #(.N(N), .M(4), .DEPTH(DEPTH), .CW(5)) u_dut (
        .clk        (clk),
        .global_rst (global_rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .end_in     (end_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .frame_rdy  (frame_rdy),
        .frame_done (frame_done),
        .short_frame(short_frame),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [N-1:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            exp_q[i] = base + N'(i);
        end
    endtask

    // Push exp_q[0..count-1] with 'gap' idle cycles between samples.
    task automatic send_frame(input int count, input int gap, input bit end_last);
        for (int i = 0; i < count; i++) begin
            valid_in = 1'b1;
            data_in  = exp_q[i];
            end_in   = end_last && (i == count - 1);
            tick();
            valid_in = 1'b0;
            end_in   = 1'b0;
            data_in  = '0;
            if (i == 0 && count > 1) begin
                check("cap_frame_rdy", 32'(frame_rdy), 32'd1);
                check("cap_dout_valid", 32'(dout_valid), 32'd0);
            end
            if (i < count - 1) begin
                repeat (gap) tick();
            end
        end
        check("drain_start_valid", 32'(dout_valid), 32'd1);
        check("drain_start_rdy", 32'(frame_rdy), 32'd0);
    endtask

    // Consume words; mode 1 drives ready 1,0,0,1 repeating. Stops after
    // 'stop' transfers; on a full drain returns in the frame_done cycle.
    task automatic drain(input int len, input int mode, input int stop);
        int           idx;
        int           cyc;
        bit           r;
        bit           pv;
        bit           pr;
        bit           pl;
        logic [N-1:0] pd;
        idx = 0;
        cyc = 0;
        pv  = 1'b0;
        pr  = 1'b1;
        pl  = 1'b0;
        pd  = '0;
        while (idx < stop && cyc < 200) begin
            r          = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            dout_ready = r;
            check("drain_valid", 32'(dout_valid), 32'd1);
            if (pv && !pr) begin
                check("hold_dout", 32'(dout), 32'(pd));
                check("hold_last", 32'(dout_last), 32'(pl));
            end
            if (dout_valid && r) begin
                check($sformatf("word%0d", idx), 32'(dout), 32'(exp_q[idx]));
                check($sformatf("last%0d", idx), 32'(dout_last), 32'(idx == len - 1));
                idx++;
            end
            pv = dout_valid;
            pr = r;
            pd = dout;
            pl = dout_last;
            tick();
            cyc++;
        end
        check("xfer_count", 32'(idx), 32'(stop));
        if (stop == len) begin
            check("done_pulse", 32'(frame_done), 32'd1);
            check("done_rdy", 32'(frame_rdy), 32'd1);
            check("done_valid", 32'(dout_valid), 32'd0);
            check("done_dout_zero", 32'(dout), 32'd0);
        end
    endtask

    initial begin
        global_rst = 1'b1;
        data_in    = '0;
        valid_in   = 1'b0;
        end_in     = 1'b0;
        dout_ready = 1'b1;
        repeat (2) tick();
        global_rst = 1'b0;
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_last", 32'(dout_last), 32'd0);
        check("rst_rdy", 32'(frame_rdy), 32'd1);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_short", 32'(short_frame), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Lone end_in in IDLE must not start anything.
        end_in = 1'b1;
        tick();
        end_in = 1'b0;
        tick();
        check("idle_end_rdy", 32'(frame_rdy), 32'd1);
        check("idle_end_valid", 32'(dout_valid), 32'd0);

        // Full frame, gaps of 3, ready held high.
        fill(16'h0001);
        send_frame(16, 3, 1'b0);
        drain(16, 0, 16);
        check("full_short", 32'(short_frame), 32'd0);
        check("full_ovf", 32'(overflow), 32'd0);
        tick();
        check("done_one_cycle", 32'(frame_done), 32'd0);

        // Backpressure 1,0,0,1.
        send_frame(16, 3, 1'b0);
        dout_ready = 1'b0;
        drain(16, 1, 16);
        dout_ready = 1'b1;
        tick();

        // Short frame: end_in with the 5th sample.
        fill(16'h0A00);
        send_frame(5, 1, 1'b1);
        drain(5, 0, 5);
        check("short_set", 32'(short_frame), 32'd1);
        check("short_ovf", 32'(overflow), 32'd0);
        tick();

        // Overflow during stalled drain.
        fill(16'h0001);
        send_frame(16, 0, 1'b0);
        dout_ready = 1'b0;
        valid_in   = 1'b1;
        data_in    = 16'h7FFF;
        tick();
        valid_in = 1'b0;
        data_in  = '0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_dout", 32'(dout), 32'h0001);
        tick();
        check("ovf_hold", 32'(dout), 32'h0001);
        drain(16, 0, 16);
        tick();

        // Reset after 7 transfers.
        fill(16'h0100);
        send_frame(16, 0, 1'b0);
        drain(16, 0, 7);
        global_rst = 1'b1;
        tick();
        global_rst = 1'b0;
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_rdy", 32'(frame_rdy), 32'd1);
        check("mid_rst_short", 32'(short_frame), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        fill(16'h0300);
        send_frame(16, 2, 1'b0);
        drain(16, 0, 16);
        tick();

        // Back-to-back: next frame starts in the frame_done cycle.
        fill(16'h0001);
        send_frame(16, 0, 1'b0);
        drain(16, 0, 16);
        fill(16'h2000);
        exp_q[0] = 16'h1234;
        send_frame(16, 0, 1'b0);
        drain(16, 0, 16);
        check("b2b_short", 32'(short_frame), 32'd0);
        check("b2b_ovf", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pool_out_buffer.md
# pool_out_buffer

Frame buffer that sits directly downstream of the accelerator's pooling output. It captures the pooled feature-map stream (`data_out`/`valid_op`/`end_op`) into an internal register array, one word per valid cycle. Once the frame is complete, it replays the frame in raster order over a valid/ready stream to the next layer or the host interface. It also reports when a new frame may be started.

## Interface
- `N`, 16, word width; matches the accelerator datapath (N,Q fixed point, passed through unmodified).
- `M`, 4, pooled map side length, equal to (n-k+1)/p for the default accelerator configuration.
- `DEPTH`, M*M (16), buffer entries, one per pooled output.
- `CW`, 5, counter width; must satisfy 2^CW > DEPTH.

- `clk`, input, 1, single clock; all state updates on the rising edge.
- `global_rst`, input, 1, reset, synchronous, active-high.
- `data_in`, input, N, pooled sample; connects to accelerator `data_out`.
- `valid_in`, input, 1, sample strobe; connects to `valid_op`.
- `end_in`, input, 1, end-of-frame indication; connects to `end_op`.
- `dout`, output, N, drained word; 0 whenever `dout_valid`=0.
- `dout_valid`, output, 1, drain stream valid.
- `dout_ready`, input, 1, drain stream ready from the consumer.
- `dout_last`, output, 1, high with the final word of the frame.
- `frame_rdy`, output, 1, high in IDLE and CAPTURE; the upstream controller may run the accelerator only while this is high.
- `frame_done`, output, 1, one-cycle pulse after the last drain transfer.
- `short_frame`, output, 1, sticky; the frame ended with fewer than DEPTH samples.
- `overflow`, output, 1, sticky; a sample was dropped.

## Operation
- States: IDLE, CAPTURE, DRAIN. Internal counters `wr_cnt` and `rd_idx` (CW bits each) and register array `mem[DEPTH]`.
- **IDLE**
  - `valid_in`=1: write `mem[0]`, set `wr_cnt`=1, go to CAPTURE.
  - `end_in` with `valid_in`=0 is ignored.
- **CAPTURE**
  - `valid_in`=1: write `mem[wr_cnt]`, then `wr_cnt`++.
  - Go to DRAIN on the edge where the DEPTH-th sample is written.
  - Also go to DRAIN on the edge where `end_in`=1. If `valid_in` is high in the same cycle, that sample is written first and counts.
  - If `end_in` moves to DRAIN with final `wr_cnt` < DEPTH, set `short_frame`.
- **DRAIN**
  - `dout_valid`=1, `dout`=`mem[rd_idx]`, `dout_last`=(`rd_idx`==`wr_cnt`-1).
  - A transfer occurs on an edge with `dout_valid` & `dout_ready`; it increments `rd_idx`.
  - Transfer with `dout_last`=1: go to IDLE, clear `wr_cnt` and `rd_idx`, pulse `frame_done` for the next cycle.
  - `valid_in` during DRAIN: sample is dropped and `overflow` is set.
  - `end_in` during DRAIN is ignored.
- **Full buffer**
  - Any `valid_in` arriving after the DEPTH-th write is handled as DRAIN (dropped, `overflow` set).
  - `mem` is never written at index ≥ DEPTH.
- **Stream rule:** `dout`, `dout_valid` and `dout_last` hold stable while `dout_valid`=1 and `dout_ready`=0.
- **Data path:** no arithmetic; words are stored and replayed bit-exact.
- **Sticky flags:** `short_frame` and `overflow` clear only on `global_rst`.

## Timing
- **Reset:** `global_rst`=1 at an edge forces the following, including mid-capture or mid-drain:
  - state IDLE, `wr_cnt`=0, `rd_idx`=0;
  - `dout`=0, `dout_valid`=0, `dout_last`=0;
  - `frame_rdy`=1, `frame_done`=0, `short_frame`=0, `overflow`=0.
  - `mem` contents are don't-care after reset.
- **Write latency:** a sample is in `mem` at the edge where `valid_in`=1.
- **Drain start:** `dout_valid` rises in the cycle immediately after the edge that enters DRAIN.
- **Throughput:** one word per cycle when `dout_ready` is held high.
  - Full-frame drain takes DEPTH cycles.
  - `frame_done` is high in cycle DEPTH+1 after drain start.
- **`frame_rdy`:**
  - Falls in the same cycle that `dout_valid` rises.
  - Rises in the same cycle that `frame_done` pulses.
- **Back-to-back frames:** `valid_in` in the `frame_done` cycle is accepted as sample 0 of the next frame.

## Test plan
- **Full frame:** reset, then 16 `valid_in` pulses carrying 0x0001..0x0010 with gaps of 3 cycles, `dout_ready`=1.
  - Expect `dout` 0x0001..0x0010 on 16 consecutive cycles.
  - Expect `dout_last` only on 0x0010, then one `frame_done` pulse.
  - Expect `short_frame`=0 and `overflow`=0.
- **Backpressure:** full frame as above, with `dout_ready` toggling 1,0,0,1 repeatedly.
  - Expect every word held stable while not ready, no word duplicated or lost, and 16 transfers total.
- **Short frame:** 5 samples 0x0A00..0x0A04, with `end_in` in the same cycle as the 5th.
  - Expect 5 words out, `dout_last` on 0x0A04, `short_frame`=1.
- **Overflow:** full frame, then `valid_in` with 0x7FFF during DRAIN while `dout_ready`=0.
  - Expect `overflow`=1 and 0x7FFF never appearing on `dout`.
  - Drain output is unchanged.
- **Reset mid-drain:** assert `global_rst` after 7 of 16 words have transferred.
  - Next cycle expect `dout_valid`=0, `dout`=0, `frame_rdy`=1.
  - A new 16-word frame then drains correctly from index 0.
- **Back-to-back:** start the second frame's first sample (0x1234) in the `frame_done` cycle.
  - Expect 0x1234 as the first word of the second drain.
